// File: rtl/rename_unit_param.sv
// Parametrised register rename stage: map table, circular free list and
// circular checkpoint buffer with rollback-by-ID and in-order release.
module rename_unit_param #(
    parameter int WIDTH        = 8,
    parameter int COMMIT_WIDTH = 8,
    parameter int ARCH_REGS    = 32,
    parameter int PHYS_REGS    = 128,
    parameter int CP_DEPTH     = 8,
    localparam int AW = $clog2(ARCH_REGS),
    localparam int PW = $clog2(PHYS_REGS),
    localparam int CW = $clog2(CP_DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           in_valid,
    output logic                       in_ready,
    input  logic [WIDTH*AW-1:0]        rs1_arch_i,
    input  logic [WIDTH*AW-1:0]        rs2_arch_i,
    input  logic [WIDTH*AW-1:0]        rd_arch_i,
    input  logic [WIDTH-1:0]           cp_req_i,
    input  logic                       alloc_ok_i,
    output logic [WIDTH*PW-1:0]        rs1_phys_o,
    output logic [WIDTH*PW-1:0]        rs2_phys_o,
    output logic [WIDTH*PW-1:0]        rd_phys_o,
    output logic [WIDTH*PW-1:0]        old_rd_phys_o,
    output logic [WIDTH-1:0]           out_valid_o,
    output logic                       cp_valid_o,
    output logic [CW-1:0]              cp_id_o,
    input  logic [COMMIT_WIDTH-1:0]    commit_valid_i,
    input  logic [COMMIT_WIDTH*PW-1:0] commit_phys_i,
    input  logic                       cp_release_i,
    input  logic                       rollback_i,
    input  logic [CW-1:0]              rollback_id_i,
    output logic [PW:0]                free_count_o,
    output logic [CW:0]                cp_count_o
);

    typedef logic [PW-1:0] phys_t;
    typedef logic [PW:0]   ptr_t;
    typedef logic [CW:0]   cptr_t;

    localparam ptr_t  PTR_ONE       = ptr_t'(1);
    localparam cptr_t CP_ONE        = cptr_t'(1);
    localparam cptr_t CP_FULL       = cptr_t'(CP_DEPTH);
    localparam ptr_t  FREE_INIT_PTR = ptr_t'(PHYS_REGS - ARCH_REGS);

    phys_t map_q       [ARCH_REGS];
    phys_t map_d       [ARCH_REGS];
    phys_t map_init    [ARCH_REGS];
    phys_t free_list_q [PHYS_REGS];
    phys_t free_list_d [PHYS_REGS];
    phys_t free_init   [PHYS_REGS];
    ptr_t  head_q, head_d, tail_q, tail_d;

    phys_t cp_map_q      [CP_DEPTH][ARCH_REGS];
    phys_t cp_map_d      [CP_DEPTH][ARCH_REGS];
    ptr_t  cp_head_ptr_q [CP_DEPTH];
    ptr_t  cp_head_ptr_d [CP_DEPTH];
    cptr_t cp_head_q, cp_head_d, cp_tail_q, cp_tail_d;

    logic [WIDTH*PW-1:0] rs1_phys_q, rs1_phys_d, rs2_phys_q, rs2_phys_d;
    logic [WIDTH*PW-1:0] rd_phys_q, rd_phys_d, old_rd_phys_q, old_rd_phys_d;
    logic [WIDTH-1:0]    out_valid_q, out_valid_d;
    logic                cp_valid_q, cp_valid_d;
    logic [CW-1:0]       cp_id_q, cp_id_d;

    ptr_t  free_count, need, alloc_ptr, snap_head, commit_ptr;
    cptr_t cp_count, live_count;
    logic  cp_wanted, accept, cp_taken, rb_live;
    logic [CW-1:0] rb_offset;
    logic [AW-1:0] rd_idx;
    phys_t new_phys;
    phys_t ren_map  [ARCH_REGS];
    phys_t snap_map [ARCH_REGS];
    logic [WIDTH*PW-1:0] ren_rs1, ren_rs2, ren_rd, ren_old;

    for (genvar i = 0; i < ARCH_REGS; i++) begin : g_map_init
        assign map_init[i] = phys_t'(i);
    end

    for (genvar i = 0; i < PHYS_REGS; i++) begin : g_free_init
        if (i < PHYS_REGS - ARCH_REGS) begin : g_used
            assign free_init[i] = phys_t'(i + ARCH_REGS);
        end else begin : g_spare
            assign free_init[i] = '0;
        end
    end

    assign free_count = tail_q - head_q;
    assign cp_count   = cp_tail_q - cp_head_q;

    // Group acceptance: enough free registers, downstream room, checkpoint room, no rollback.
    always_comb begin
        need      = '0;
        cp_wanted = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            if (in_valid[k] && rd_arch_i[k*AW +: AW] != '0) begin
                need = need + PTR_ONE;
            end
            if (in_valid[k] && cp_req_i[k]) begin
                cp_wanted = 1'b1;
            end
        end
        in_ready = alloc_ok_i && (free_count >= need) && !rollback_i
                   && !(cp_wanted && cp_count == CP_FULL);
        accept   = (|in_valid) && in_ready;
    end

    // In-order rename through a running map so later slots see earlier writers.
    always_comb begin
        ren_map   = map_q;
        snap_map  = map_q;
        alloc_ptr = head_q;
        snap_head = head_q;
        cp_taken  = 1'b0;
        rd_idx    = '0;
        new_phys  = '0;
        ren_rs1   = '0;
        ren_rs2   = '0;
        ren_rd    = '0;
        ren_old   = '0;
        for (int k = 0; k < WIDTH; k++) begin
            rd_idx   = rd_arch_i[k*AW +: AW];
            new_phys = '0;
            ren_rs1[k*PW +: PW] = ren_map[rs1_arch_i[k*AW +: AW]];
            ren_rs2[k*PW +: PW] = ren_map[rs2_arch_i[k*AW +: AW]];
            ren_old[k*PW +: PW] = ren_map[rd_idx];
            if (in_valid[k] && rd_idx != '0) begin
                new_phys        = free_list_q[alloc_ptr[PW-1:0]];
                alloc_ptr       = alloc_ptr + PTR_ONE;
                ren_map[rd_idx] = new_phys;
            end
            ren_rd[k*PW +: PW] = new_phys;
            if (in_valid[k] && cp_req_i[k] && !cp_taken) begin
                cp_taken  = 1'b1;
                snap_map  = ren_map;
                snap_head = alloc_ptr;
            end
        end
    end

    // Push committed registers at the tail in lane order, skipping x0's register.
    always_comb begin
        free_list_d = free_list_q;
        commit_ptr  = tail_q;
        for (int c = 0; c < COMMIT_WIDTH; c++) begin
            if (commit_valid_i[c] && commit_phys_i[c*PW +: PW] != '0) begin
                free_list_d[commit_ptr[PW-1:0]] = commit_phys_i[c*PW +: PW];
                commit_ptr = commit_ptr + PTR_ONE;
            end
        end
        tail_d = commit_ptr;
    end

    // Rollback wins over rename; release pops the oldest live checkpoint after any restore.
    always_comb begin
        map_d         = map_q;
        head_d        = head_q;
        cp_map_d      = cp_map_q;
        cp_head_ptr_d = cp_head_ptr_q;
        cp_head_d     = cp_head_q;
        cp_tail_d     = cp_tail_q;
        rb_offset     = rollback_id_i - cp_head_q[CW-1:0];
        rb_live       = rollback_i && ({1'b0, rb_offset} < cp_count);
        live_count    = cp_count;
        if (rb_live) begin
            map_d      = cp_map_q[rollback_id_i];
            head_d     = cp_head_ptr_q[rollback_id_i];
            cp_tail_d  = cp_head_q + {1'b0, rb_offset} + CP_ONE;
            live_count = {1'b0, rb_offset} + CP_ONE;
        end else if (accept) begin
            map_d  = ren_map;
            head_d = alloc_ptr;
            if (cp_taken) begin
                cp_map_d[cp_tail_q[CW-1:0]]      = snap_map;
                cp_head_ptr_d[cp_tail_q[CW-1:0]] = snap_head;
                cp_tail_d                        = cp_tail_q + CP_ONE;
            end
        end
        if (cp_release_i && live_count != '0) begin
            cp_head_d = cp_head_q + CP_ONE;
        end
    end

    // Registered rename results; operand fields hold their last accepted group.
    always_comb begin
        out_valid_d   = accept ? in_valid : '0;
        cp_valid_d    = accept && cp_taken;
        cp_id_d       = cp_valid_d ? cp_tail_q[CW-1:0] : cp_id_q;
        rs1_phys_d    = accept ? ren_rs1 : rs1_phys_q;
        rs2_phys_d    = accept ? ren_rs2 : rs2_phys_q;
        rd_phys_d     = accept ? ren_rd  : rd_phys_q;
        old_rd_phys_d = accept ? ren_old : old_rd_phys_q;
    end

    // All state updates on the rising edge, with synchronous re-initialisation.
    always_ff @(posedge clk) begin
        if (rst) begin
            map_q         <= map_init;
            free_list_q   <= free_init;
            head_q        <= '0;
            tail_q        <= FREE_INIT_PTR;
            cp_map_q      <= '{default: '0};
            cp_head_ptr_q <= '{default: '0};
            cp_head_q     <= '0;
            cp_tail_q     <= '0;
            out_valid_q   <= '0;
            cp_valid_q    <= 1'b0;
            cp_id_q       <= '0;
            rs1_phys_q    <= '0;
            rs2_phys_q    <= '0;
            rd_phys_q     <= '0;
            old_rd_phys_q <= '0;
        end else begin
            map_q         <= map_d;
            free_list_q   <= free_list_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            cp_map_q      <= cp_map_d;
            cp_head_ptr_q <= cp_head_ptr_d;
            cp_head_q     <= cp_head_d;
            cp_tail_q     <= cp_tail_d;
            out_valid_q   <= out_valid_d;
            cp_valid_q    <= cp_valid_d;
            cp_id_q       <= cp_id_d;
            rs1_phys_q    <= rs1_phys_d;
            rs2_phys_q    <= rs2_phys_d;
            rd_phys_q     <= rd_phys_d;
            old_rd_phys_q <= old_rd_phys_d;
        end
    end

    assign rs1_phys_o    = rs1_phys_q;
    assign rs2_phys_o    = rs2_phys_q;
    assign rd_phys_o     = rd_phys_q;
    assign old_rd_phys_o = old_rd_phys_q;
    assign out_valid_o   = out_valid_q;
    assign cp_valid_o    = cp_valid_q;
    assign cp_id_o       = cp_id_q;
    assign free_count_o  = free_count;
    assign cp_count_o    = cp_count;

endmodule
